// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// One operation is in flight at a time. Operands are registered into the ALU,
// the result and flags are captured one cycle later, and the response is held
// until the owning requester takes it. Round-robin priority flips only when a
// response completes, so a lone requester can be served back to back.
module alu_arbiter #(
    parameter int WORD_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              CLK,
    input  logic              RST,

    // requester 0
    input  logic              req0_valid,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [WORD_W-1:0] req0_a,
    input  logic [WORD_W-1:0] req0_b,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [WORD_W-1:0] rsp0_result,
    output logic [2:0]        rsp0_flags,
    input  logic              rsp0_ready,

    // requester 1
    input  logic              req1_valid,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [WORD_W-1:0] req1_a,
    input  logic [WORD_W-1:0] req1_b,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [WORD_W-1:0] rsp1_result,
    output logic [2:0]        rsp1_flags,
    input  logic              rsp1_ready,

    // shared ALU
    output logic [OP_W-1:0]   alu_op,
    output logic [WORD_W-1:0] alu_a,
    output logic [WORD_W-1:0] alu_b,
    input  logic [WORD_W-1:0] alu_out,
    input  logic              alu_neg,
    input  logic              alu_zero,
    input  logic              alu_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // sequencer state
    state_t                   state_reg;
    logic                     prio_reg;
    logic                     owner_reg;

    // operand registers feeding the ALU
    logic [OP_W-1:0]          op_reg;
    logic [WORD_W-1:0]        a_reg;
    logic [WORD_W-1:0]        b_reg;

    // per-requester captured responses; the non-owner keeps its last value
    logic [1:0][WORD_W-1:0]   result_reg;
    logic [1:0][2:0]          flags_reg;
    logic [1:0]               rsp_valid_reg;

    // requester ports gathered into indexable vectors
    logic [1:0]               req_valid;
    logic [1:0][OP_W-1:0]     req_op;
    logic [1:0][WORD_W-1:0]   req_a;
    logic [1:0][WORD_W-1:0]   req_b;
    logic [1:0]               rsp_ready;

    logic [1:0]               ready_vec;
    logic [1:0]               rsp_valid_vec;
    logic [1:0][WORD_W-1:0]   rsp_result_vec;
    logic [1:0][2:0]          rsp_flags_vec;

    logic                     grant_idx;
    logic                     accept;
    logic                     done;

    assign req_valid = {req1_valid, req0_valid};
    assign req_op    = {req1_op, req0_op};
    assign req_a     = {req1_a, req0_a};
    assign req_b     = {req1_b, req0_b};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    // Grant selection: a lone requester wins outright, a tie goes to prio.
    always_comb begin
        grant_idx = prio_reg;
        if (req_valid == 2'b01) begin
            grant_idx = 1'b0;
        end else if (req_valid == 2'b10) begin
            grant_idx = 1'b1;
        end
    end

    // Per-requester handshake and response outputs, all forced low in reset.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign ready_vec[gi]      = !RST && (state_reg == IDLE)
                                        && req_valid[gi] && (grant_idx == 1'(gi));
            assign rsp_valid_vec[gi]  = !RST && rsp_valid_reg[gi];
            assign rsp_result_vec[gi] = RST ? '0 : result_reg[gi];
            assign rsp_flags_vec[gi]  = RST ? '0 : flags_reg[gi];
        end
    endgenerate

    assign accept = |ready_vec;
    assign done   = (state_reg == RESP) && rsp_ready[owner_reg];

    assign req0_ready  = ready_vec[0];
    assign req1_ready  = ready_vec[1];
    assign rsp0_valid  = rsp_valid_vec[0];
    assign rsp1_valid  = rsp_valid_vec[1];
    assign rsp0_result = rsp_result_vec[0];
    assign rsp1_result = rsp_result_vec[1];
    assign rsp0_flags  = rsp_flags_vec[0];
    assign rsp1_flags  = rsp_flags_vec[1];

    // The ALU only ever sees registered operands, never live requester inputs.
    assign alu_op = RST ? '0 : op_reg;
    assign alu_a  = RST ? '0 : a_reg;
    assign alu_b  = RST ? '0 : b_reg;

    // Sequencer: accept in IDLE, capture ALU result in EXEC, hold in RESP.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= IDLE;
            prio_reg      <= 1'b0;
            owner_reg     <= 1'b0;
            op_reg        <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            result_reg    <= '0;
            flags_reg     <= '0;
            rsp_valid_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_reg    <= req_op[grant_idx];
                        a_reg     <= req_a[grant_idx];
                        b_reg     <= req_b[grant_idx];
                        owner_reg <= grant_idx;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    result_reg[owner_reg]    <= alu_out;
                    flags_reg[owner_reg]     <= {alu_ovf, alu_neg, alu_zero};
                    rsp_valid_reg[owner_reg] <= 1'b1;
                    state_reg                <= RESP;
                end
                RESP: begin
                    if (done) begin
                        rsp_valid_reg <= '0;
                        prio_reg      <= ~owner_reg;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
